// File: rtl/ram_arbiter_ctrl.sv
// rtl/ram_arbiter_ctrl.sv - round-robin multi-port RAM controller with fixed latency, sub-word access and error reporting
module ram_arbiter_ctrl #(
    parameter int NPORTS       = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int LAT          = 2,
    parameter int REORDER_DATA = 0
) (
    input  logic                         ram_clk,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            req_ren,
    input  logic [NPORTS-1:0]            req_wen,
    input  logic [NPORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NPORTS*2-1:0]          req_width,
    input  logic [NPORTS-1:0]            req_unsigned,
    input  logic [NPORTS*32-1:0]         req_store,
    output logic [NPORTS-1:0]            resp_valid,
    output logic [31:0]                  resp_load,
    output logic                         resp_error,
    output logic [1:0]                   ram_state
);
    localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        RAM_FREE  = 2'b00,
        RAM_ADDR  = 2'b01,
        RAM_DATA  = 2'b10,
        RAM_ERROR = 2'b11
    } state_t;

    state_t                state;
    logic [GW-1:0]         grant, last_grant, next_grant;
    logic [GW:0]           cand;
    logic                  any_req, grant_req;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] lat_addr, sel_addr;
    logic [1:0]            lat_width, sel_width;
    logic                  lat_unsigned, sel_unsigned, lat_write, sel_write;
    logic [31:0]           lat_store, sel_store;
    logic [NPORTS-1:0]     req_any;
    logic [31:0]           mem [DEPTH_WORDS];

    logic [IW-1:0]         widx;
    logic [1:0]            lane;
    logic                  illegal, do_write;
    logic [31:0]           raw_word, view, shifted, ins_data, rd_data, new_view;
    logic [3:0]            lane_mask;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign req_any   = req_ren | req_wen;
    assign ram_state = state;

    // Walk offsets from farthest to nearest so the closest requester after last_grant wins.
    always_comb begin
        next_grant = '0;
        any_req    = 1'b0;
        cand       = '0;
        for (int off = NPORTS; off >= 1; off--) begin
            cand = {1'b0, last_grant} + (GW+1)'(off);
            if (cand >= (GW+1)'(NPORTS))
                cand = cand - (GW+1)'(NPORTS);
            for (int p = 0; p < NPORTS; p++) begin
                if (req_any[p] && cand == (GW+1)'(p)) begin
                    next_grant = GW'(p);
                    any_req    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_addr     = '0;
        sel_width    = '0;
        sel_unsigned = 1'b0;
        sel_write    = 1'b0;
        sel_store    = '0;
        grant_req    = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (next_grant == GW'(p)) begin
                sel_addr     = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_width    = req_width[p*2 +: 2];
                sel_unsigned = req_unsigned[p];
                sel_write    = req_wen[p];
                sel_store    = req_store[p*32 +: 32];
            end
            if (grant == GW'(p))
                grant_req = req_ren[p] | req_wen[p];
        end
    end

    assign widx    = lat_addr[2 +: IW];
    assign lane    = lat_addr[1:0];
    assign illegal = (lat_width == 2'b11)
                  || (lat_width == 2'b01 && lat_addr[0])
                  || (lat_width == 2'b10 && lat_addr[1:0] != 2'b00)
                  || ((lat_addr >> (IW + 2)) != '0);

    // The bus always sees little-endian lanes; reordering only affects the stored image.
    assign raw_word = mem[widx];
    assign view     = (REORDER_DATA != 0) ? bswap(raw_word) : raw_word;
    assign shifted  = view >> {lane, 3'b000};
    assign ins_data = lat_store << {lane, 3'b000};

    always_comb begin
        rd_data   = view;
        lane_mask = 4'b1111;
        case (lat_width)
            2'b00: begin
                rd_data   = {{24{~lat_unsigned & shifted[7]}}, shifted[7:0]};
                lane_mask = 4'b0001 << lane;
            end
            2'b01: begin
                rd_data   = {{16{~lat_unsigned & shifted[15]}}, shifted[15:0]};
                lane_mask = 4'b0011 << lane;
            end
            default: ;
        endcase
        new_view = view;
        for (int k = 0; k < 4; k++)
            new_view[8*k +: 8] = lane_mask[k] ? ins_data[8*k +: 8] : view[8*k +: 8];
    end

    assign do_write = (state == RAM_ADDR) && grant_req && (cnt == 4'(LAT)) && !illegal && lat_write;

    always_ff @(posedge ram_clk) begin
        if (!rst && do_write)
            mem[widx] <= (REORDER_DATA != 0) ? bswap(new_view) : new_view;
    end

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            state        <= RAM_FREE;
            cnt          <= '0;
            grant        <= '0;
            last_grant   <= GW'(NPORTS - 1);
            lat_addr     <= '0;
            lat_width    <= '0;
            lat_unsigned <= 1'b0;
            lat_write    <= 1'b0;
            lat_store    <= '0;
            resp_valid   <= '0;
            resp_load    <= '0;
            resp_error   <= 1'b0;
        end else begin
            case (state)
                RAM_FREE: begin
                    if (any_req) begin
                        grant        <= next_grant;
                        lat_addr     <= sel_addr;
                        lat_width    <= sel_width;
                        lat_unsigned <= sel_unsigned;
                        lat_write    <= sel_write;
                        lat_store    <= sel_store;
                        cnt          <= '0;
                        state        <= RAM_ADDR;
                    end
                end
                RAM_ADDR: begin
                    if (!grant_req) begin
                        state <= RAM_FREE;
                    end else if (cnt == 4'(LAT)) begin
                        resp_valid <= NPORTS'(1) << grant;
                        if (illegal) begin
                            state      <= RAM_ERROR;
                            resp_error <= 1'b1;
                            resp_load  <= '0;
                        end else begin
                            state      <= RAM_DATA;
                            resp_error <= 1'b0;
                            resp_load  <= lat_write ? 32'd0 : rd_data;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    resp_valid <= '0;
                    resp_load  <= '0;
                    resp_error <= 1'b0;
                    last_grant <= grant;
                    state      <= RAM_FREE;
                end
            endcase
        end
    end
endmodule
